// File: rtl/display_pkg.sv
`default_nettype none
// ============================================================================
// Module      : display_pkg
// Description : Shared constants, load-FSM state type and the leading-zero
//               blanking helper for the four-digit display scanner.
// Revision    : 1.0 - initial release
// ============================================================================
package display_pkg;

  localparam int         NUM_DIGITS          = 4;
  localparam logic [3:0] AN_OFF              = 4'b1111;
  localparam int         REFRESH_DIV_DEFAULT = 50000;

  typedef enum logic [0:0] {
    LOAD_EMPTY   = 1'b0,
    LOAD_PENDING = 1'b1
  } load_state_e;

  // A position is a leading zero when it and every more-significant nibble
  // are zero. The rightmost position is never treated as leading so that a
  // value of zero still lights one digit.
  function automatic logic lead_blank(input logic [15:0] value,
                                      input logic [1:0]  pos);
    logic blank;
    blank = (pos != 2'd0);
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if ((k >= int'(pos)) && (value[4*k +: 4] != 4'h0)) begin
        blank = 1'b0;
      end
    end
    return blank;
  endfunction

endpackage
`default_nettype wire

// File: rtl/refresh_tick_gen.sv
`default_nettype none
// ============================================================================
// Module      : refresh_tick_gen
// Description : Refresh prescaler. Counts 0..REFRESH_DIV-1 and wraps; tick is
//               high for the single cycle in which the count is at its top.
// Ports       : clk  - system clock (rising edge)
//               rst  - synchronous active-high reset
//               tick - one-cycle strobe once every REFRESH_DIV cycles
// Revision    : 1.0 - initial release
// ============================================================================
module refresh_tick_gen
  import display_pkg::*;
#(
  parameter int REFRESH_DIV = REFRESH_DIV_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam int             CNT_W    = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(REFRESH_DIV - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    tick  = (cnt_q == LAST_CNT);
    cnt_d = tick ? '0 : cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/display_scanner.sv
`default_nettype none
// ============================================================================
// Module      : display_scanner
// Description : Time-multiplexed driver for a four-digit seven-segment
//               display. A new 16-bit value is accepted through a
//               valid/ready handshake into a pending register and moved into
//               the displayed (shadow) register only at a frame boundary, so
//               a frame never mixes old and new digits. Optional leading-zero
//               blanking.
// Ports       : clk        - system clock (rising edge)
//               rst        - synchronous active-high reset
//               load_valid - new display value offered
//               load_data  - four hex nibbles, [3:0] is the rightmost digit
//               load_ready - value can be accepted this cycle
//               blank_lz   - enable leading-zero blanking
//               digit      - nibble for the external 7-segment decoder
//               an         - active-low digit enables, an[k] drives digit k
// Revision    : 1.0 - initial release
// ============================================================================
module display_scanner
  import display_pkg::*;
#(
  parameter int REFRESH_DIV = REFRESH_DIV_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load_valid,
  input  logic [15:0] load_data,
  output logic        load_ready,
  input  logic        blank_lz,
  output logic [3:0]  digit,
  output logic [3:0]  an
);

  logic        tick;
  logic        frame_end;

  load_state_e state_q, state_d;
  logic [1:0]  idx_q, idx_d;
  logic [15:0] pending_q, pending_d;
  logic [15:0] shadow_q, shadow_d;
  logic [3:0]  digit_q, digit_d;
  logic [3:0]  an_q, an_d;

  refresh_tick_gen #(
    .REFRESH_DIV (REFRESH_DIV)
  ) u_tick_gen (
    .clk  (clk),
    .rst  (rst),
    .tick (tick)
  );

  always_comb begin
    idx_d     = tick ? idx_q + 2'd1 : idx_q;
    frame_end = tick && (idx_q == 2'd3);

    // Ready is masked by rst directly so that it reads low during reset and
    // high in the very first cycle after reset releases.
    load_ready = (state_q == LOAD_EMPTY) && !rst;

    state_d   = state_q;
    pending_d = pending_q;
    shadow_d  = shadow_q;

    case (state_q)
      LOAD_EMPTY: begin
        // A transfer on a frame-end cycle still waits a full frame: the
        // shadow is only ever fed from the pending register.
        if (load_valid && load_ready) begin
          pending_d = load_data;
          state_d   = LOAD_PENDING;
        end
      end
      LOAD_PENDING: begin
        if (frame_end) begin
          shadow_d = pending_q;
          state_d  = LOAD_EMPTY;
        end
      end
      default: begin
        state_d = LOAD_EMPTY;
      end
    endcase

    digit_d = shadow_q[{idx_q, 2'b00} +: 4];
    an_d    = AN_OFF;
    if (!(blank_lz && lead_blank(shadow_q, idx_q))) begin
      an_d[idx_q] = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= LOAD_EMPTY;
      idx_q     <= 2'd0;
      pending_q <= 16'h0000;
      shadow_q  <= 16'h0000;
      digit_q   <= 4'h0;
      an_q      <= AN_OFF;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      pending_q <= pending_d;
      shadow_q  <= shadow_d;
      digit_q   <= digit_d;
      an_q      <= an_d;
    end
  end

  assign digit = digit_q;
  assign an    = an_q;

endmodule
`default_nettype wire

// File: doc/display_scanner.md
DISPLAY_SCANNER -- requirements
Module: display_scanner

Interface
REQ-001 The block SHALL have parameter REFRESH_DIV, default 50000, meaning clk cycles per digit slot (≥2).
REQ-002 The block SHALL have port clk  input  1  single system clock, all logic on rising edge.
REQ-003 The block SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-004 The block SHALL have port load_valid  input  1  new display value offered.
REQ-005 The block SHALL have port load_data  input  16  four hex nibbles, [3:0]=digit 0 (rightmost).
REQ-006 The block SHALL have port load_ready  output  1  block can accept load_data this cycle.
REQ-007 The block SHALL have port blank_lz  input  1  enable leading-zero blanking.
REQ-008 The block SHALL have port digit  output  4  nibble for the downstream 4-bit-to-7-segment decoder.
REQ-009 The block SHALL have port an  output  4  active-low digit enables, an[k] drives digit k.

Function
REQ-010 Prescaler SHALL count 0..REFRESH_DIV-1, wrap to 0, and assert internal tick for one cycle at REFRESH_DIV-1.
REQ-011 Digit index idx (2 bits) SHALL increment on tick, wrapping 3->0; frame boundary = tick with idx==3.
REQ-012 Load path SHALL be a two-state FSM: EMPTY (load_ready=1), PENDING (load_ready=0).
REQ-013 Transfer SHALL occur on the clock edge where load_valid && load_ready; load_data is captured into the pending register and the FSM goes EMPTY->PENDING.
REQ-014 In PENDING, at a frame boundary, the pending register SHALL copy to the shadow register and the FSM SHALL return to EMPTY.
REQ-015 A transfer coinciding with a frame boundary while EMPTY SHALL go to PENDING, with the shadow update at the next boundary (no bypass).
REQ-016 load_valid while PENDING SHALL be ignored; load_data need not be held stable.
REQ-017 Shadow SHALL change only at frame boundaries; no digit of a frame mixes old and new values.
REQ-018 digit and an SHALL be registered: each cycle they reflect the idx and shadow of the previous cycle (1-cycle latency).
REQ-019 an SHALL be all-ones except bit idx, which is 0 unless that position is blanked.
REQ-020 With blank_lz=1, position k∈{3,2,1} SHALL be blanked (an[k]=1) iff shadow nibbles k..3 are all zero; position 0 SHALL never be blanked.
REQ-021 Blanked positions SHALL still output their nibble (0) on digit.
REQ-022 blank_lz SHALL be sampled every cycle with no frame alignment.

Reset
REQ-023 While rst=1: prescaler=0, idx=0, shadow=16'h0000, pending=16'h0000, FSM=EMPTY, load_ready=0, digit=4'h0, an=4'b1111.
REQ-024 load_ready SHALL be 1 in the first cycle after rst deasserts; an SHALL be 4'b1110 one cycle after rst deasserts.
REQ-025 Reset asserted mid-frame or in PENDING SHALL discard the pending value and take effect on the next edge.

Structure
REQ-026 Package display_pkg SHALL hold NUM_DIGITS=4, AN_OFF=4'b1111, the default REFRESH_DIV, and the load FSM state enum.
REQ-027 The prescaler SHALL be sub-module refresh_tick_gen (parameter REFRESH_DIV; ports clk, rst, tick).
REQ-028 RTL SHALL be synthesizable SystemVerilog, no latches, 120-400 lines total.

Verification (benches use REFRESH_DIV=4)
REQ-029 Reset release -> an sequence 1110,1101,1011,0111 with four cycles each, repeating; digit=0.
REQ-030 Load 16'h3A5F when idle -> load_ready=0 next cycle; after the next frame boundary, digits 0..3 show F,5,A,3; load_ready returns to 1.
REQ-031 Load 16'h1111 in PENDING with 16'h2222 offered -> the second offer is ignored; the display shows 1111 only.
REQ-032 blank_lz=1, value 16'h0070 -> an[3], an[2] stay 1; digit 1 (7) and digit 0 (0) are enabled; with 16'h0000, only digit 0 is enabled.
REQ-033 Load accepted on the exact frame-boundary cycle -> the shadow updates one frame later, never mid-frame.
REQ-034 rst pulsed while PENDING with 16'hBEEF -> the display returns to 0000 and BEEF never appears.
